// File: rtl/regfile_pkg.sv
// Shared sizing defaults and constants for the register file with
// write-back staging and busy scoreboard.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned DEFAULT_DEPTH  = 32;

    // Architectural zero register: reads 0, ignores writes and busy marking.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_stage_reg.sv
// One-entry write-back staging register: holds a captured write for one
// edge before it commits into the array.
module regfile_stage_reg
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic [DATA_W-1:0] next_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else begin
            valid <= load;
            if (load) begin
                addr <= next_addr;
                data <= next_data;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with a staged write-back port, read bypass from the
// staging entry, and a per-register busy scoreboard for hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    output logic              stage_valid
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              stage_load;
    logic [ADDR_W-1:0] stage_addr;
    logic [DATA_W-1:0] stage_data;

    assign stage_load = we && (waddr != ZERO_ADDR);

    regfile_stage_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (stage_load),
        .next_addr (waddr),
        .next_data (wdata),
        .valid     (stage_valid),
        .addr      (stage_addr),
        .data      (stage_data)
    );

    // Commit the staged write one edge after capture; reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (stage_valid) begin
            mem[stage_addr] <= stage_data;
        end
    end

    // The set is issued after the clear so a new producer wins over a
    // retiring one on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (we) begin
                busy[waddr] <= 1'b0;
            end
            if (set_busy && (set_addr != ZERO_ADDR)) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata1 = mem[raddr1];
        if (raddr1 == ZERO_ADDR) begin
            rdata1 = '0;
        end else if (stage_valid && (stage_addr == raddr1)) begin
            rdata1 = stage_data;
        end
    end

    always_comb begin
        rdata2 = mem[raddr2];
        if (raddr2 == ZERO_ADDR) begin
            rdata2 = '0;
        end else if (stage_valid && (stage_addr == raddr2)) begin
            rdata2 = stage_data;
        end
    end

    assign rbusy1 = busy[raddr1];
    assign rbusy2 = busy[raddr2];

endmodule
